// File: rtl/ahb_sram_pkg.sv
// Shared types and constants for the AHB SRAM subordinate.
//   state_t       : data-phase FSM states
//   HTRANS_*      : AHB transfer-type encodings
//   HRESP_*       : AHB response encodings
//   trans_active  : true for NONSEQ/SEQ transfer types
//   size_aligned  : legal HSIZE (byte/half/word) and address aligned to it
package ahb_sram_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    ERR1,
    ERR2
  } state_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam int unsigned WAIT_W = 4;

  function automatic logic trans_active(input logic [1:0] htrans);
    logic act;
    act = 1'b0;
    case (htrans)
      HTRANS_NONSEQ, HTRANS_SEQ: act = 1'b1;
      HTRANS_IDLE, HTRANS_BUSY:  act = 1'b0;
    endcase
    return act;
  endfunction

  // Sizes above a word are illegal for a 32-bit SRAM.
  function automatic logic size_aligned(input logic [2:0] hsize, input logic [1:0] lsb);
    logic ok;
    ok = 1'b0;
    case (hsize)
      3'd0:    ok = 1'b1;
      3'd1:    ok = ~lsb[0];
      3'd2:    ok = (lsb == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/ahb_if.sv
// AHB-Lite bus bundle between one manager and one subordinate.
//   subordinate modport: address/control/write data in, HREADYOUT/HRESP/HRDATA out
//   manager modport    : the mirror image
interface ahb_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic [3:0]  HWSTRB;
  logic        HREADY;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;

  modport subordinate (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HWSTRB, HREADY,
    output HREADYOUT, HRESP, HRDATA
  );

  modport manager (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HWSTRB, HREADY,
    input  HREADYOUT, HRESP, HRDATA
  );
endinterface

// File: rtl/ahb_sram_subordinate_counter.sv
// Generic up-counter with synchronous clear and rollover.
//   clk, nRST     : clock, async active-low reset
//   clear         : force count to zero (wins over count_enable)
//   count_enable  : advance by one, wrapping to zero after rollover_val
//   rollover_val  : terminal count
//   count_out     : current count
//   rollover_flag : registered, high while count_out == rollover_val
module ahb_sram_subordinate_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             nRST,
  input  logic             clear,
  input  logic             count_enable,
  input  logic [WIDTH-1:0] rollover_val,
  output logic [WIDTH-1:0] count_out,
  output logic             rollover_flag
);

  logic [WIDTH-1:0] count_d;

  // Next count.
  always_comb begin
    count_d = count_out;
    if (clear) begin
      count_d = '0;
    end else if (count_enable) begin
      count_d = (count_out == rollover_val) ? '0 : count_out + WIDTH'(1);
    end
  end

  // Count and flag registers.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      count_out     <= '0;
      rollover_flag <= 1'b0;
    end else begin
      count_out     <= count_d;
      rollover_flag <= (count_d == rollover_val);
    end
  end

endmodule

// File: rtl/ahb_sram_subordinate.sv
// AHB-Lite subordinate backed by a byte-strobed 32-bit SRAM array with a
// fixed number of wait states per OKAY transfer and two-cycle ERROR responses.
//   clk, nRST : clock, async active-low reset (storage is not reset)
//   ahb       : subordinate side of the AHB bundle (HSEL..HREADY in,
//               HREADYOUT/HRESP/HRDATA out, all outputs registered)
module ahb_sram_subordinate
  import ahb_sram_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic            clk,
  input  logic            nRST,
  ahb_if.subordinate      ahb
);

  localparam int unsigned      IDX_W      = $clog2(DEPTH_WORDS);
  localparam logic [31:0]      SPAN_BYTES = 32'(4 * DEPTH_WORDS);
  localparam logic [WAIT_W-1:0] WAIT_VAL  = WAIT_W'(WAIT_STATES);

  logic [31:0] mem [DEPTH_WORDS];

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              write_q, write_d;
  logic              hreadyout_q, hreadyout_d;
  logic              hresp_q, hresp_d;
  logic [31:0]       hrdata_q, hrdata_d;

  logic              cnt_clear, cnt_en, waits_done;
  logic [WAIT_W-1:0] cnt_out;

  logic [32:0]       addr_diff;
  logic              addr_ok, accept, complete, wr_en, ready_next;
  logic [31:0]       rd_word;

  ahb_sram_subordinate_counter #(.WIDTH(WAIT_W)) u_wait_cnt (
    .clk           (clk),
    .nRST          (nRST),
    .clear         (cnt_clear),
    .count_enable  (cnt_en),
    .rollover_val  (WAIT_VAL),
    .count_out     (cnt_out),
    .rollover_flag (waits_done)
  );

  // Address decode: 33-bit difference so addresses below the base show up as a borrow.
  assign addr_diff = {1'b0, ahb.HADDR} - {1'b0, BASE_ADDR};
  assign addr_ok   = !addr_diff[32] && (addr_diff[31:0] < SPAN_BYTES)
                     && size_aligned(ahb.HSIZE, ahb.HADDR[1:0]);
  assign accept    = ahb.HSEL && ahb.HREADY && trans_active(ahb.HTRANS);
  assign complete  = (state_q == ACCESS) && waits_done;
  assign wr_en     = complete && write_q;

  // Read word for the next data phase, forwarding bytes committed on this same edge.
  always_comb begin
    rd_word = mem[idx_d];
    for (int i = 0; i < 4; i++) begin
      if (wr_en && (idx_q == idx_d) && ahb.HWSTRB[i]) begin
        rd_word[8*i +: 8] = ahb.HWDATA[8*i +: 8];
      end
    end
  end

  // Next state, counter control and next-cycle output values.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    write_d     = write_q;
    cnt_clear   = 1'b0;
    cnt_en      = 1'b0;
    ready_next  = 1'b1;
    hreadyout_d = 1'b1;
    hresp_d     = HRESP_OKAY;
    hrdata_d    = '0;

    case (state_q)
      IDLE:    state_d = IDLE;
      ACCESS:  begin
        if (waits_done) state_d = IDLE;
        else            cnt_en  = 1'b1;
      end
      ERR1:    state_d = ERR2;
      ERR2:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // New address phases are only taken while this subordinate is not mid data phase.
    if (accept && ((state_q == IDLE) || (state_q == ERR2) || complete)) begin
      state_d   = addr_ok ? ACCESS : ERR1;
      idx_d     = ahb.HADDR[IDX_W+1:2];
      write_d   = ahb.HWRITE;
      cnt_clear = 1'b1;
      cnt_en    = 1'b0;
    end

    ready_next = cnt_clear ? (WAIT_VAL == '0) : ((cnt_out + WAIT_W'(1)) == WAIT_VAL);

    case (state_d)
      ACCESS: begin
        hreadyout_d = ready_next;
        if (ready_next && !write_d) hrdata_d = rd_word;
      end
      ERR1: begin
        hreadyout_d = 1'b0;
        hresp_d     = HRESP_ERROR;
      end
      ERR2: begin
        hreadyout_d = 1'b1;
        hresp_d     = HRESP_ERROR;
      end
      default: ;
    endcase
  end

  // State, registered control and registered outputs.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      write_q     <= 1'b0;
      hreadyout_q <= 1'b1;
      hresp_q     <= HRESP_OKAY;
      hrdata_q    <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      write_q     <= write_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
      hrdata_q    <= hrdata_d;
    end
  end

  // Storage: byte-lane writes on the completion edge; HSIZE does not mask lanes.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (ahb.HWSTRB[i]) mem[idx_q][8*i +: 8] <= ahb.HWDATA[8*i +: 8];
      end
    end
  end

  assign ahb.HREADYOUT = hreadyout_q;
  assign ahb.HRESP     = hresp_q;
  assign ahb.HRDATA    = hrdata_q;

endmodule

// File: tb/tb_ahb_sram_subordinate.sv
// Bench for ahb_sram_subordinate: two instances (0 and 3 wait states) share
// one pipelined manager; expectations are queued when an address phase is
// accepted and compared when the matching data phase completes.
module tb_ahb_sram_subordinate;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic        exp_resp;
    logic [31:0] exp_rdata;
  } vec_t;

  typedef struct {
    logic        resp;
    logic [31:0] rdata;
    int          waits;
  } exp_t;

  logic        clk;
  logic        nRST;
  logic        hsel0, hsel3, hwrite;
  logic [31:0] haddr, hwdata;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic [3:0]  hwstrb;

  int errors;
  int checks;
  vec_t txq[$];
  exp_t sb[$];

  ahb_if bus0 ();
  ahb_if bus3 ();

  assign bus0.HSEL = hsel0;  assign bus3.HSEL = hsel3;
  assign bus0.HADDR = haddr; assign bus3.HADDR = haddr;
  assign bus0.HTRANS = htrans; assign bus3.HTRANS = htrans;
  assign bus0.HWRITE = hwrite; assign bus3.HWRITE = hwrite;
  assign bus0.HSIZE = hsize; assign bus3.HSIZE = hsize;
  assign bus0.HWDATA = hwdata; assign bus3.HWDATA = hwdata;
  assign bus0.HWSTRB = hwstrb; assign bus3.HWSTRB = hwstrb;
  assign bus0.HREADY = bus0.HREADYOUT;
  assign bus3.HREADY = bus3.HREADYOUT;

  ahb_sram_subordinate #(.BASE_ADDR(32'h0), .DEPTH_WORDS(1024), .WAIT_STATES(0)) dut0 (
    .clk(clk), .nRST(nRST), .ahb(bus0)
  );
  ahb_sram_subordinate #(.BASE_ADDR(32'h0), .DEPTH_WORDS(64), .WAIT_STATES(3)) dut3 (
    .clk(clk), .nRST(nRST), .ahb(bus3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                              input logic [31:0] wdata, input logic [3:0] strb,
                              input logic exp_resp, input logic [31:0] exp_rdata);
    vec_t v;
    v.wr = wr; v.addr = addr; v.size = size; v.wdata = wdata; v.strb = strb;
    v.exp_resp = exp_resp; v.exp_rdata = exp_rdata;
    return v;
  endfunction

  function automatic logic rd_ready(input int tgt);
    return (tgt == 0) ? bus0.HREADYOUT : bus3.HREADYOUT;
  endfunction
  function automatic logic rd_resp(input int tgt);
    return (tgt == 0) ? bus0.HRESP : bus3.HRESP;
  endfunction
  function automatic logic [31:0] rd_data(input int tgt);
    return (tgt == 0) ? bus0.HRDATA : bus3.HRDATA;
  endfunction

  function automatic logic [31:0] line_word(input int i);
    return 32'h5A5A_0000 ^ (32'(i) << 8) ^ 32'(i * 7);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic bus_idle();
    hsel0 = 1'b0; hsel3 = 1'b0; haddr = '0; htrans = 2'b00;
    hwrite = 1'b0; hsize = 3'd0; hwdata = '0; hwstrb = '0;
  endtask

  // Pipelined manager: holds each NONSEQ until accepted, data follows one phase later.
  task automatic run_seq(input int tgt, input string tag);
    vec_t dp;
    exp_t e;
    logic dp_valid;
    logic bad;
    int   waits;
    int   cyc;
    int   nominal;
    int   n;
    dp_valid = 1'b0; bad = 1'b0; waits = 0; cyc = 0; n = 0;
    nominal = (tgt == 0) ? 0 : 3;
    while ((txq.size() > 0 || dp_valid) && cyc < 2000) begin
      cyc++;
      if (txq.size() > 0) begin
        hsel0 = (tgt == 0); hsel3 = (tgt == 3);
        haddr = txq[0].addr; htrans = 2'b10; hwrite = txq[0].wr; hsize = txq[0].size;
      end else begin
        hsel0 = 1'b0; hsel3 = 1'b0; haddr = '0; htrans = 2'b00; hwrite = 1'b0; hsize = 3'd0;
      end
      hwdata = dp_valid ? dp.wdata : 32'h0;
      hwstrb = dp_valid ? dp.strb : 4'h0;
      @(negedge clk);
      if (dp_valid) begin
        if (!rd_ready(tgt)) begin
          waits++;
          if (rd_resp(tgt) !== sb[0].resp || rd_data(tgt) !== 32'h0) bad = 1'b1;
        end else begin
          e = sb.pop_front();
          check($sformatf("%s[%0d] resp", tag, n), 32'(rd_resp(tgt)), 32'(e.resp));
          check($sformatf("%s[%0d] rdata", tag, n), rd_data(tgt), e.rdata);
          check($sformatf("%s[%0d] waits", tag, n), 32'(waits), 32'(e.waits));
          check($sformatf("%s[%0d] wait-cycle outputs", tag, n), 32'(bad), 32'h0);
          dp_valid = 1'b0;
          n++;
        end
      end
      if (rd_ready(tgt) && txq.size() > 0) begin
        dp = txq.pop_front();
        dp_valid = 1'b1; waits = 0; bad = 1'b0;
        e.resp = dp.exp_resp; e.rdata = dp.exp_rdata; e.waits = dp.exp_resp ? 1 : nominal;
        sb.push_back(e);
      end
      @(posedge clk); #1;
    end
    if (cyc >= 2000) begin
      checks++; errors++;
      $display("FAIL %s timeout: got no completion within %0d cycles", tag, cyc);
      txq.delete(); sb.delete();
    end
    bus_idle();
  endtask

  vec_t tab_a[17];
  vec_t tab_c[7];

  initial begin
    errors = 0; checks = 0;
    nRST = 1'b0;
    bus_idle();
    repeat (2) @(posedge clk);
    #1;
    check("reset HREADYOUT dut0", 32'(bus0.HREADYOUT), 32'h1);
    check("reset HRESP dut0", 32'(bus0.HRESP), 32'h0);
    check("reset HRDATA dut0", bus0.HRDATA, 32'h0);
    check("reset HREADYOUT dut3", 32'(bus3.HREADYOUT), 32'h1);
    check("reset HRESP dut3", 32'(bus3.HRESP), 32'h0);
    check("reset HRDATA dut3", bus3.HRDATA, 32'h0);
    @(negedge clk) nRST = 1'b1;
    @(posedge clk); #1;

    // Zero-wait instance: back-to-back, strobes, forwarding, error decode.
    tab_a[0]  = mk(1, 32'h10,   3'd2, 32'hDEADBEEF, 4'hF, 0, 32'h0);
    tab_a[1]  = mk(0, 32'h10,   3'd2, 32'h0,        4'h0, 0, 32'hDEADBEEF);
    tab_a[2]  = mk(1, 32'h20,   3'd2, 32'h11111111, 4'hF, 0, 32'h0);
    tab_a[3]  = mk(1, 32'h20,   3'd2, 32'hAABBCCDD, 4'h5, 0, 32'h0);
    tab_a[4]  = mk(0, 32'h20,   3'd2, 32'h0,        4'h0, 0, 32'h11BB11DD);
    tab_a[5]  = mk(1, 32'h0,    3'd2, 32'h01020304, 4'hF, 0, 32'h0);
    tab_a[6]  = mk(1, 32'h1000, 3'd2, 32'hFFFFFFFF, 4'hF, 1, 32'h0);
    tab_a[7]  = mk(0, 32'h0,    3'd2, 32'h0,        4'h0, 0, 32'h01020304);
    tab_a[8]  = mk(1, 32'h0,    3'd3, 32'hFFFFFFFF, 4'hF, 1, 32'h0);
    tab_a[9]  = mk(1, 32'h2,    3'd2, 32'hFFFFFFFF, 4'hF, 1, 32'h0);
    tab_a[10] = mk(1, 32'h1,    3'd1, 32'hFFFFFFFF, 4'hF, 1, 32'h0);
    tab_a[11] = mk(0, 32'h0,    3'd2, 32'h0,        4'h0, 0, 32'h01020304);
    tab_a[12] = mk(1, 32'h3,    3'd0, 32'h77000000, 4'h8, 0, 32'h0);
    tab_a[13] = mk(0, 32'h2,    3'd1, 32'h0,        4'h0, 0, 32'h77020304);
    tab_a[14] = mk(0, 32'h1000, 3'd2, 32'h0,        4'h0, 1, 32'h0);
    tab_a[15] = mk(1, 32'h20,   3'd0, 32'h99887766, 4'hF, 0, 32'h0);
    tab_a[16] = mk(0, 32'h20,   3'd2, 32'h0,        4'h0, 0, 32'h99887766);
    for (int i = 0; i < 17; i++) txq.push_back(tab_a[i]);
    run_seq(0, "A");

    // Sixteen-word line written then read back.
    for (int i = 0; i < 16; i++)
      txq.push_back(mk(1, 32'h40 + 32'(4 * i), 3'd2, line_word(i), 4'hF, 0, 32'h0));
    for (int i = 0; i < 16; i++)
      txq.push_back(mk(0, 32'h40 + 32'(4 * i), 3'd2, 32'h0, 4'h0, 0, line_word(i)));
    run_seq(0, "LINE");

    // Three-wait instance: NONSEQ held across waits, error still two cycles.
    tab_c[0] = mk(1, 32'h0,   3'd2, 32'hA5A50F0F, 4'hF, 0, 32'h0);
    tab_c[1] = mk(1, 32'h4,   3'd2, 32'h12345678, 4'hF, 0, 32'h0);
    tab_c[2] = mk(0, 32'h0,   3'd2, 32'h0,        4'h0, 0, 32'hA5A50F0F);
    tab_c[3] = mk(0, 32'h4,   3'd2, 32'h0,        4'h0, 0, 32'h12345678);
    tab_c[4] = mk(1, 32'h100, 3'd2, 32'hFFFFFFFF, 4'hF, 1, 32'h0);
    tab_c[5] = mk(0, 32'h0,   3'd2, 32'h0,        4'h0, 0, 32'hA5A50F0F);
    tab_c[6] = mk(1, 32'h8,   3'd2, 32'h11223344, 4'hF, 0, 32'h0);
    for (int i = 0; i < 7; i++) txq.push_back(tab_c[i]);
    run_seq(3, "C");

    // Once the bus goes idle no extra access may follow.
    begin
      int low;
      low = 0;
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        if (bus3.HREADYOUT !== 1'b1) low++;
      end
      check("C idle after last access: low cycles", 32'(low), 32'h0);
    end

    // Reset asserted during the wait states of a write to 0x8.
    @(posedge clk); #1;
    hsel3 = 1'b1; haddr = 32'h8; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd2;
    @(negedge clk);
    check("RST address phase ready", 32'(bus3.HREADYOUT), 32'h1);
    @(posedge clk); #1;
    hsel3 = 1'b0; haddr = '0; htrans = 2'b00; hwrite = 1'b0;
    hwdata = 32'hFFFFFFFF; hwstrb = 4'hF;
    @(negedge clk);
    check("RST write in wait state", 32'(bus3.HREADYOUT), 32'h0);
    #1 nRST = 1'b0;
    #1;
    check("RST HREADYOUT immediate", 32'(bus3.HREADYOUT), 32'h1);
    check("RST HRESP immediate", 32'(bus3.HRESP), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    nRST = 1'b1;
    bus_idle();
    @(posedge clk); #1;

    txq.push_back(mk(0, 32'h8, 3'd2, 32'h0, 4'h0, 0, 32'h11223344));
    run_seq(3, "RST3");
    txq.push_back(mk(0, 32'h10, 3'd2, 32'h0, 4'h0, 0, 32'hDEADBEEF));
    txq.push_back(mk(0, 32'h7C, 3'd2, 32'h0, 4'h0, 0, line_word(15)));
    run_seq(0, "RST0");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
